// File: rtl/counter_seq_ctrl_if.sv
// Command/status bundle between the control logic and the counter sequencer.
// The master drives start/pause/abort and the configuration; the slave
// (the sequencer) returns the count value, state and event pulses.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] cfg_load_val;
  logic             cfg_dir;
  logic             cfg_mode;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, pause, abort, cfg_load_val, cfg_dir, cfg_mode,
    input  count, busy, tc, done, state
  );

  modport slave (
    input  start, pause, abort, cfg_load_val, cfg_dir, cfg_mode,
    output count, busy, tc, done, state
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit counter.
// A start in IDLE latches limit, direction and mode into shadow registers,
// then the counter steps towards its terminal value. One-shot runs finish
// through a single DONE cycle; auto-reload runs restart from the start value.
// Pause freezes the count, abort drops straight back to IDLE with count 0.
module counter_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  counter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] terminal_val;
  logic             at_term;

  // Start and terminal values derived from the latched configuration.
  always_comb begin
    reload_val   = dir_q ? ZERO : lim_q;
    terminal_val = dir_q ? lim_q : ZERO;
    at_term      = (count_q == terminal_val);
  end

  // Next-state logic; abort outranks start/pause, which outrank counting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = 1'b0;
    lim_d   = lim_q;
    dir_d   = dir_q;
    mode_d  = mode_q;

    case (state_q)
      IDLE: begin
        if (bus.abort) begin
          count_d = ZERO;
        end else if (bus.start) begin
          lim_d   = bus.cfg_load_val;
          dir_d   = bus.cfg_dir;
          mode_d  = bus.cfg_mode;
          count_d = bus.cfg_dir ? ZERO : bus.cfg_load_val;
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          count_d = ZERO;
        end else if (bus.pause) begin
          state_d = PAUSE;
        end else if (at_term) begin
          tc_d = 1'b1;
          if (mode_q) begin
            count_d = reload_val;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (dir_q) begin
          count_d = count_q + ONE;
        end else begin
          count_d = count_q - ONE;
        end
      end

      PAUSE: begin
        if (bus.abort) begin
          state_d = IDLE;
          count_d = ZERO;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        count_d = ZERO;
      end
    endcase
  end

  // Sequencer registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= ZERO;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      lim_q   <= ZERO;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  // Status outputs, all taken from registered state.
  always_comb begin
    bus.count = count_q;
    bus.tc    = tc_q;
    bus.done  = done_q;
    bus.state = state_q;
    bus.busy  = (state_q == RUN) || (state_q == PAUSE);
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl.
// A run-step model predicts count/state/tc/done/busy every cycle, and
// directed scenarios also pin key cycles against hand-computed literals.
module tb_counter_seq_ctrl;

  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  counter_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int mState = 0;
  int mK     = 0;
  int mIdle  = 0;
  int mLim   = 0;
  int mDir   = 0;
  int mMode  = 0;
  int mTc    = 0;
  int mDone  = 0;

  function automatic int modelCount();
    if (mState == 1 || mState == 2) return (mDir != 0) ? mK : (mLim - mK);
    if (mState == 3) return (mDir != 0) ? mLim : 0;
    return mIdle;
  endfunction

  task automatic compareField(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: mK counts completed run steps since the last (re)load.
  always @(posedge clk or negedge rst_n) begin
    int nS;
    int sT;
    int sD;
    if (!rst_n) begin
      mState = 0; mK = 0; mIdle = 0; mLim = 0;
      mDir = 0; mMode = 0; mTc = 0; mDone = 0;
    end else begin
      nS = mState; sT = 0; sD = 0;
      case (mState)
        0: begin
          if (bus.abort) mIdle = 0;
          else if (bus.start) begin
            mLim = int'(bus.cfg_load_val); mDir = int'(bus.cfg_dir);
            mMode = int'(bus.cfg_mode); mK = 0; nS = 1;
          end
        end
        1: begin
          if (bus.abort) begin nS = 0; mIdle = 0; end
          else if (bus.pause) nS = 2;
          else if (mK == mLim) begin
            sT = 1;
            if (mMode != 0) mK = 0;
            else begin nS = 3; sD = 1; end
          end else mK = mK + 1;
        end
        2: begin
          if (bus.abort) begin nS = 0; mIdle = 0; end
          else if (!bus.pause) nS = 1;
        end
        default: begin
          nS = 0; mIdle = (mDir != 0) ? mLim : 0;
        end
      endcase
      mState = nS; mTc = sT; mDone = sD;
    end
  end

  // Cycle-by-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    compareField("model_count", int'(bus.count), modelCount());
    compareField("model_state", int'(bus.state), mState);
    compareField("model_tc",    int'(bus.tc),    mTc);
    compareField("model_done",  int'(bus.done),  mDone);
    compareField("model_busy",  int'(bus.busy),  (mState == 1 || mState == 2) ? 1 : 0);
  end

  task automatic applyStimulus(input logic st, input logic pa, input logic ab,
                               input int lv, input logic dr, input logic md);
    bus.start        = st;
    bus.pause        = pa;
    bus.abort        = ab;
    bus.cfg_load_val = WIDTH'(lv);
    bus.cfg_dir      = dr;
    bus.cfg_mode     = md;
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int c, input int s,
                             input int t, input int d, input int b);
    compareField({name, "_count"}, int'(bus.count), c);
    compareField({name, "_state"}, int'(bus.state), s);
    compareField({name, "_tc"},    int'(bus.tc),    t);
    compareField({name, "_done"},  int'(bus.done),  d);
    compareField({name, "_busy"},  int'(bus.busy),  b);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0);
    #12;
    checkOutput("reset", 0, 0, 0, 0, 0);
    #11 rst_n = 1'b1;
    cycle();

    $display("[TB] down one-shot, lim=3");
    applyStimulus(1, 0, 0, 3, 0, 0); cycle();
    applyStimulus(0, 0, 0, 3, 0, 0);
    checkOutput("down_c1", 3, 1, 0, 0, 1); cycle();
    checkOutput("down_c2", 2, 1, 0, 0, 1); cycle();
    checkOutput("down_c3", 1, 1, 0, 0, 1); cycle();
    checkOutput("down_c4", 0, 1, 0, 0, 1); cycle();
    checkOutput("down_c5", 0, 3, 1, 1, 0); cycle();
    checkOutput("down_c6", 0, 0, 0, 0, 0); cycle();

    $display("[TB] up auto-reload, lim=2, then abort");
    applyStimulus(1, 0, 0, 2, 1, 1); cycle();
    applyStimulus(0, 0, 0, 2, 1, 1);
    checkOutput("upar_c1", 0, 1, 0, 0, 1); cycle();
    checkOutput("upar_c2", 1, 1, 0, 0, 1); cycle();
    checkOutput("upar_c3", 2, 1, 0, 0, 1); cycle();
    checkOutput("upar_c4", 0, 1, 1, 0, 1); cycle();
    checkOutput("upar_c5", 1, 1, 0, 0, 1); cycle();
    checkOutput("upar_c6", 2, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 2, 1, 1); cycle();
    applyStimulus(0, 0, 0, 2, 1, 1);
    checkOutput("upar_abort", 0, 0, 0, 0, 0); cycle();

    $display("[TB] pause mid-run, lim=5");
    applyStimulus(1, 0, 0, 5, 0, 0); cycle();
    applyStimulus(0, 0, 0, 5, 0, 0);
    checkOutput("pause_c1", 5, 1, 0, 0, 1); cycle(); cycle();
    checkOutput("pause_c3", 3, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 5, 0, 0); cycle();
    checkOutput("pause_c4", 3, 2, 0, 0, 1); cycle(); cycle(); cycle();
    checkOutput("pause_c7", 3, 2, 0, 0, 1);
    applyStimulus(0, 0, 0, 5, 0, 0); cycle();
    checkOutput("pause_c8", 3, 1, 0, 0, 1); cycle();
    checkOutput("pause_c9", 2, 1, 0, 0, 1); cycle(); cycle();
    checkOutput("pause_c11", 0, 1, 0, 0, 1); cycle();
    checkOutput("pause_c12", 0, 3, 1, 1, 0); cycle();

    $display("[TB] abort while paused");
    applyStimulus(1, 0, 0, 7, 1, 1); cycle();
    applyStimulus(0, 1, 0, 7, 1, 1); cycle();
    checkOutput("pabort_c2", 0, 2, 0, 0, 1);
    applyStimulus(0, 1, 1, 7, 1, 1); cycle();
    applyStimulus(0, 0, 0, 7, 1, 1);
    checkOutput("pabort_c3", 0, 0, 0, 0, 0); cycle();

    $display("[TB] ignored commands, up one-shot lim=4");
    applyStimulus(1, 0, 0, 4, 1, 0); cycle();
    checkOutput("ign_c1", 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 9, 0, 1); cycle();
    applyStimulus(0, 0, 0, 4, 1, 0);
    checkOutput("ign_c2", 1, 1, 0, 0, 1); cycle(); cycle(); cycle();
    checkOutput("ign_c5", 4, 1, 0, 0, 1); cycle();
    checkOutput("ign_c6", 4, 3, 1, 1, 0);
    applyStimulus(1, 0, 1, 4, 1, 0); cycle();
    applyStimulus(0, 1, 0, 4, 1, 0);
    checkOutput("ign_c7", 4, 0, 0, 0, 0); cycle();
    checkOutput("ign_c8", 4, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 4, 1, 0); cycle();
    applyStimulus(0, 0, 0, 4, 1, 0);
    checkOutput("ign_c9", 0, 0, 0, 0, 0); cycle();

    $display("[TB] lim=0 one-shot and auto-reload");
    applyStimulus(1, 0, 0, 0, 0, 0); cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lim0_c1", 0, 1, 0, 0, 1); cycle();
    checkOutput("lim0_c2", 0, 3, 1, 1, 0); cycle();
    checkOutput("lim0_c3", 0, 0, 0, 0, 0); cycle();
    applyStimulus(1, 0, 0, 0, 0, 1); cycle();
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("lim0ar_c1", 0, 1, 0, 0, 1);
    for (int i = 2; i <= 5; i++) begin
      cycle();
      checkOutput("lim0ar_tc", 0, 1, 1, 0, 1);
    end
    applyStimulus(0, 0, 1, 0, 0, 1); cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lim0ar_abort", 0, 0, 0, 0, 0); cycle();

    $display("[TB] reset mid-run");
    applyStimulus(1, 0, 0, 10, 0, 0); cycle();
    applyStimulus(0, 0, 0, 10, 0, 0);
    repeat (6) cycle();
    checkOutput("rst_before", 4, 1, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_async", 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    cycle();
    applyStimulus(1, 0, 0, 255, 0, 0); cycle();
    applyStimulus(0, 0, 0, 255, 0, 0);
    checkOutput("rst_new_c1", 255, 1, 0, 0, 1); cycle();
    checkOutput("rst_new_c2", 254, 1, 0, 0, 1);
    repeat (3) cycle();
    checkOutput("rst_new_c5", 251, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 255, 0, 0); cycle();
    applyStimulus(0, 0, 0, 255, 0, 0);
    checkOutput("rst_new_abort", 0, 0, 0, 0, 0); cycle();

    $display("[TB] up one-shot to 255");
    applyStimulus(1, 0, 0, 255, 1, 0); cycle();
    applyStimulus(0, 0, 0, 255, 1, 0);
    repeat (256) cycle();
    checkOutput("up255_done", 255, 3, 1, 1, 0); cycle();
    checkOutput("up255_idle", 255, 0, 0, 0, 0); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for a WIDTH-bit counter register built from async-reset flops.
- Accepts a start command with a configuration, runs the counter up or down to a terminal value, then stops (one-shot) or reloads (auto-reload).
- Supports pause and abort; reports busy, done and terminal-count events to the surrounding control logic.

Parameters:
- WIDTH, 8, counter and load-value width in bits (legal range 2..32).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  start pulse; sampled only in IDLE.
- pause  input  1  level; while high, a running count holds.
- abort  input  1  pulse; returns the block to IDLE from any state.
- cfg_load_val  input  WIDTH  count limit; captured on an accepted start.
- cfg_dir  input  1  0 = count down from load_val to 0; 1 = count up from 0 to load_val. Captured on start.
- cfg_mode  input  1  0 = one-shot; 1 = auto-reload. Captured on start.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high in RUN or PAUSE.
- tc  output  1  one-cycle pulse, one cycle after count equals the terminal value.
- done  output  1  one-cycle pulse on completion of a one-shot run.
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, count=0, tc=0, done=0, busy=0, shadow cfg registers=0. No event pulses are generated for the interrupted run.
- Shadow registers: lim, dir and mode are latched from the cfg_* inputs on an accepted start. cfg_* changes afterwards have no effect until the next start.
- Start value and terminal value:
  - dir=0: start value = lim, terminal = 0.
  - dir=1: start value = 0, terminal = lim.
- Priority each cycle: abort > start/pause > count step.
- IDLE:
  - start=1 at edge N: state=RUN and count=start value at N+1.
  - count otherwise holds.
  - pause is ignored.
- RUN:
  - If count != terminal: count steps by ±1 per cycle (modulo 2^WIDTH; it never wraps in legal operation).
  - If count == terminal and mode=0: next cycle state=DONE, tc=1, done=1, count holds at terminal.
  - If count == terminal and mode=1: next cycle tc=1, count=start value, stay RUN. Period = lim+1 cycles.
  - pause=1 at an edge: state=PAUSE, count holds. This takes precedence over the terminal check.
- PAUSE: count holds and tc/done stay 0. When pause=0 at an edge, state=RUN and counting resumes on the following edge.
- DONE: lasts exactly one cycle, then IDLE. start, pause and abort are ignored in DONE.
- abort=1 in RUN or PAUSE: next cycle state=IDLE, count=0, no tc, no done. abort in IDLE clears count to 0.
- start outside IDLE is ignored (no re-latch, no restart).
- lim=0: the first RUN cycle already matches terminal, so tc/done follow after 1 RUN cycle.
- tc and done are registered, never high for more than one consecutive cycle in one-shot mode. In auto-reload with lim=0, tc is high every cycle.
- busy is decoded from the registered state.

Test Plan:
- Down one-shot: cfg_dir=0, mode=0, load_val=3, start at cycle 0 -> count 3,2,1,0 on cycles 1..4; tc=done=1 and state=DONE on cycle 5; IDLE on cycle 6 with count=0 held; busy high on cycles 1..4.
- Up auto-reload: dir=1, mode=1, load_val=2, start -> count 0,1,2,0,1,2,...; tc pulses every 3rd cycle; done never asserts; abort -> IDLE, count=0, no tc.
- Pause mid-run: dir=0, load_val=5, pause high for 4 cycles at count=3 -> state=PAUSE, count stays 3 for those cycles; after release resumes 2,1,0; tc/done timing shifted by the pause duration plus 1.
- Ignored commands: start pulse and cfg_load_val change while RUN -> no effect on the count sequence; start in DONE cycle ignored; pause in IDLE ignored.
- Boundary lim=0: dir=0, mode=0, load_val=0 -> cycle 1 count=0/RUN; cycle 2 tc=done=1/DONE; cycle 3 IDLE. With mode=1: tc high every cycle from cycle 2.
- Reset mid-run: assert rst_n=0 asynchronously between edges at count=4 of an 8-bit down run -> outputs immediately 0/IDLE; after release, a new start with load_val=255 counts from 255 correctly.
